act_bit_serializer: RTL and testbench
=====================================

Name: act_bit_serializer

Overview:
Writer-side front end for the bit-serial activation FIFO. Accepts one parallel INT activation word per valid/ready handshake. Emits the low `prec` bits of that word MSB-first, one bit per cycle, as push strobes into the activation FIFO, and stalls on FIFO full. Sits between the activation buffer/loader and the FIFO that feeds the FP-INT MAC array.

Parameters:
MAX_PREC, 8, widest activation precision supported; width of in_data
CNT_W, 4, width of the bit counter and the precision port; must satisfy 2^CNT_W > MAX_PREC

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  parallel word available
in_ready  out  1  serializer can accept a word this cycle
in_data  in  MAX_PREC  activation word; only bits [prec-1:0] are used
precision  in  CNT_W  bits per word; sampled only on accept
fifo_full  in  1  FIFO full flag (combinational from the FIFO)
fifo_wr_en  out  1  FIFO push strobe
fifo_din  out  1  serial bit pushed into the FIFO
word_done  out  1  1-cycle pulse registered after the last bit of a word is pushed
busy  out  1  a word is held or being shifted

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, bit count=0, latched prec=0, word_done=0, hold register empty. Outputs in_ready=1, fifo_wr_en=0, fifo_din=0, busy=0. Any partial word is discarded; no FIFO push occurs while rst=0.
- Precision mapping at accept: 0 maps to MAX_PREC; values > MAX_PREC clamp to MAX_PREC; otherwise p=precision.
- FSM IDLE -> SHIFT:
  - Accept happens when in_valid && in_ready.
  - On accept: shreg <= in_data left-aligned so bit p-1 sits at the MSB; cnt <= p-1; next state SHIFT.
- SHIFT:
  - fifo_wr_en = (state==SHIFT) && !fifo_full (combinational); fifo_din = shreg MSB.
  - On each push: shreg shifts left by 1, cnt decrements.
  - On the push with cnt==0, the word is complete: word_done pulses the next cycle, and the FSM goes to IDLE (or loads the next word, see Optional Feature).
  - While fifo_full=1: hold state, no push, bits are not lost or duplicated.
- in_ready without the feature: high only in IDLE.
- Latency: first push occurs the cycle after accept, if not full. A word of p bits takes p push cycles. Throughput is p+1 cycles per word due to the IDLE bubble.
- busy = (state==SHIFT) || hold valid.
- in_data and precision changing during SHIFT have no effect.
- Bit order is MSB-first, matching the MAC's shift-accumulate convention.

Optional Feature:
Macro ACT_SER_PREFETCH_EN.
- Defined:
  - Adds a one-entry hold register (data plus mapped prec); in_ready = !hold_valid.
  - An accept during SHIFT fills the hold register.
  - On the last-bit push with hold valid, the held word loads straight into shreg/cnt and the FSM stays in SHIFT.
  - Result: zero-bubble back-to-back words, p cycles per word.
  - An accept in IDLE with hold empty loads shreg directly.
- Not defined: no hold register; in_ready = (state==IDLE); one bubble cycle per word.

Decomposition:
- Shared package act_pkg: MAX_PREC, CNT_W, state encoding localparams (IDLE=0, SHIFT=1), and a prec-mapping function (0/overflow -> MAX_PREC). The FIFO-side precision gating uses the same function.
- No sub-module: a single flat module; the hold register is inline under the macro.

Test Plan:
- Reset/idle: after rst release, with no in_valid -> in_ready=1, fifo_wr_en=0, busy=0 for 10 cycles.
- Basic word: in_data=8'hB5, precision=8, fifo_full=0 -> pushes 1,0,1,1,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; word_done pulses once.
- Reduced/edge precision:
  - precision=4, in_data=8'hF6 -> pushes 0,1,1,0 only.
  - precision=0 -> treated as 8 bits.
  - precision=12 -> treated as 8 bits.
- Backpressure: precision=4, in_data=4'hA, fifo_full=1 for cycles 2–4 after accept -> no push in those cycles; sequence 1,0,1,0 is delivered intact with no dup/drop.
- Back-to-back: two words of 4'h9 and 4'h6 offered continuously:
  - Without ACT_SER_PREFETCH_EN: 9 cycles from first accept to last push, one fifo_wr_en=0 gap.
  - With ACT_SER_PREFETCH_EN: 8 consecutive pushes 1,0,0,1,0,1,1,0.
- Mid-word reset: assert rst after 3 of 8 bits pushed -> fifo_wr_en=0 immediately; after release the FSM is in IDLE, no leftover bits are pushed, and a new word serializes correctly.

Source files
------------

// File: rtl/act_bit_serializer_pkg.sv
// Shared definitions for the bit-serial activation path: precision limits,
// serializer state encoding and the precision-mapping helper.
package act_pkg;

  localparam int MAX_PREC = 8;
  localparam int CNT_W    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Precision 0 and anything wider than the datapath both mean full width.
  function automatic int map_prec(input int prec, input int max_prec);
    if (prec == 0 || prec > max_prec) return max_prec;
    return prec;
  endfunction

endpackage

// File: rtl/act_bit_serializer.sv
// Parallel-to-serial front end for the activation FIFO, MSB-first.
// Build option ACT_SER_PREFETCH_EN adds a one-word hold register for zero-bubble streaming.
module act_bit_serializer #(
  parameter int MAX_PREC = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_PREC-1:0] in_data,
  input  logic [CNT_W-1:0]    precision,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic                fifo_din,
  output logic                word_done,
  output logic                busy
);
  import act_pkg::*;

  // Handshake: a word transfers on any cycle where in_valid && in_ready;
  // in_valid must stay high with stable data until that cycle.
  state_e              state_q, state_d;
  logic [MAX_PREC-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                word_done_q, word_done_d;
  logic                hold_valid;

  logic                accept;
  logic                push;
  logic                last;
  logic [CNT_W-1:0]    in_p;
  logic [MAX_PREC-1:0] in_aligned;

  assign in_p       = CNT_W'(map_prec(int'(precision), MAX_PREC));
  assign in_aligned = in_data << (MAX_PREC - int'(in_p));

  assign push       = (state_q == SHIFT) && !fifo_full;
  assign last       = push && (cnt_q == '0);
  assign accept     = in_valid && in_ready;

  assign fifo_wr_en = push;
  assign fifo_din   = shreg_q[MAX_PREC-1];
  assign word_done  = word_done_q;
  assign busy       = (state_q == SHIFT) || hold_valid;

`ifdef ACT_SER_PREFETCH_EN
  logic [MAX_PREC-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                hold_valid_q, hold_valid_d;

  assign hold_valid = hold_valid_q;
  assign in_ready   = !hold_valid_q;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    word_done_d  = last;
    hold_data_d  = hold_data_q;
    hold_cnt_d   = hold_cnt_q;
    hold_valid_d = hold_valid_q;
    if (push) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - CNT_W'(1);
    end
    if (state_q == IDLE) begin
      if (hold_valid_q) begin
        shreg_d      = hold_data_q;
        cnt_d        = hold_cnt_q;
        hold_valid_d = 1'b0;
        state_d      = SHIFT;
      end else if (accept) begin
        shreg_d = in_aligned;
        cnt_d   = in_p - CNT_W'(1);
        state_d = SHIFT;
      end
    end else begin
      if (last) begin
        if (hold_valid_q) begin
          shreg_d      = hold_data_q;
          cnt_d        = hold_cnt_q;
          hold_valid_d = 1'b0;
        end else if (!accept) begin
          state_d = IDLE;
        end
      end
      // A word arriving on the final push of the current one bypasses the hold.
      if (accept) begin
        if (last) begin
          shreg_d = in_aligned;
          cnt_d   = in_p - CNT_W'(1);
        end else begin
          hold_data_d  = in_aligned;
          hold_cnt_d   = in_p - CNT_W'(1);
          hold_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data_q  <= '0;
      hold_cnt_q   <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_valid_q <= hold_valid_d;
    end
  end
`else
  assign hold_valid = 1'b0;
  assign in_ready   = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    word_done_d = last;
    if (push) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - CNT_W'(1);
    end
    if (state_q == IDLE) begin
      if (accept) begin
        shreg_d = in_aligned;
        cnt_d   = in_p - CNT_W'(1);
        state_d = SHIFT;
      end
    end else if (last) begin
      state_d = IDLE;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

endmodule

// File: tb/tb_act_bit_serializer.sv
// Directed bench for act_bit_serializer; push stream captured at negedge and
// compared against hand-computed bit sequences.
module tb_act_bit_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] precision;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic       fifo_din;
  logic       word_done;
  logic       busy;

  int checks;
  int errors;
  int cyc;
  int done_cnt;
  int acc_cyc;
  int acc_first;
  int gaps;

  logic [0:0] got_q[$];
  int         got_cyc[$];
  logic [0:0] exp_q[$];

  act_bit_serializer #(.MAX_PREC(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .precision(precision), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .word_done(word_done),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // push monitor
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      got_q.push_back(fifo_din);
      got_cyc.push_back(cyc);
    end
    if (word_done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    done_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [7:0] d, input logic [3:0] p);
    int n;
    in_valid  = 1'b1;
    in_data   = d;
    precision = p;
    for (n = 0; n < 100; n++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (n == 100) chk("accept_timeout", 32'(n), 32'(0));
    acc_cyc = cyc;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = 8'h00;
    precision = 4'd0;
  endtask

  task automatic wait_pushes(input int n);
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() >= n) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_bit%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; done_cnt = 0;
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; precision = 4'd0; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'(1));
    chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("rst_din", 32'(fifo_din), 32'(0));
    chk("rst_done", 32'(word_done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b1;

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(in_ready), 32'(1));
      chk("idle_wr_en", 32'(fifo_wr_en), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
    end

    // basic full-width word
    clear_mon();
    send(8'hB5, 4'd8);
    chk("basic_busy", 32'(busy), 32'(1));
    wait_pushes(8);
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    chk_seq("basic");
    if (got_cyc.size() == 8) begin
      chk("basic_first_lat", 32'(got_cyc[0] - acc_cyc), 32'(1));
      chk("basic_span", 32'(got_cyc[7] - got_cyc[0]), 32'(7));
    end else chk("basic_cyc_len", 32'(got_cyc.size()), 32'(8));
    chk("basic_done", 32'(done_cnt), 32'(1));
    chk("basic_idle_busy", 32'(busy), 32'(0));

    // precision 4
    clear_mon();
    send(8'hF6, 4'd4);
    wait_pushes(4);
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b0};
    chk_seq("p4");
    chk("p4_done", 32'(done_cnt), 32'(1));

    // precision 0 means 8
    clear_mon();
    send(8'h5A, 4'd0);
    wait_pushes(8);
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    chk_seq("p0");

    // precision 12 clamps to 8
    clear_mon();
    send(8'hC3, 4'd12);
    wait_pushes(8);
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    chk_seq("p12");

    // backpressure: full during cycles acc+2 .. acc+4
    clear_mon();
    send(8'h0A, 4'd4);
    @(negedge clk);
    fifo_full = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    fifo_full = 1'b0;
    wait_pushes(4);
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    chk_seq("bp");
    if (got_cyc.size() == 4) begin
      chk("bp_cyc0", 32'(got_cyc[0] - acc_cyc), 32'(1));
      chk("bp_cyc1", 32'(got_cyc[1] - acc_cyc), 32'(5));
      chk("bp_cyc3", 32'(got_cyc[3] - acc_cyc), 32'(7));
    end else chk("bp_cyc_len", 32'(got_cyc.size()), 32'(4));
    chk("bp_done", 32'(done_cnt), 32'(1));

    // back-to-back words
    clear_mon();
    send(8'h09, 4'd4);
    acc_first = acc_cyc;
    send(8'h06, 4'd4);
    wait_pushes(8);
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    chk_seq("b2b");
    gaps = 0;
    for (int i = 1; i < got_cyc.size(); i++)
      if (got_cyc[i] - got_cyc[i-1] != 1) gaps++;
`ifdef ACT_SER_PREFETCH_EN
    if (got_cyc.size() == 8) chk("b2b_span", 32'(got_cyc[7] - acc_first), 32'(8));
    chk("b2b_gaps", 32'(gaps), 32'(0));
`else
    if (got_cyc.size() == 8) chk("b2b_span", 32'(got_cyc[7] - acc_first), 32'(9));
    chk("b2b_gaps", 32'(gaps), 32'(1));
`endif
    chk("b2b_done", 32'(done_cnt), 32'(2));

    // mid-word reset after 3 pushes
    clear_mon();
    send(8'hB5, 4'd8);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mrst_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_ready", 32'(in_ready), 32'(1));
    repeat (3) @(negedge clk);
    exp_q = '{1'b1, 1'b0, 1'b1};
    chk_seq("mrst_partial");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_no_leftover", 32'(got_q.size()), 32'(3));
    chk("mrst_idle_busy", 32'(busy), 32'(0));
    clear_mon();
    send(8'h3C, 4'd8);
    wait_pushes(8);
    exp_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    chk_seq("mrst_new");
    chk("mrst_new_done", 32'(done_cnt), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
